// File: rtl/ann_pkg.sv
// Shared definitions for the fully-connected layer blocks: scheduler state
// encoding and the neuron result-width helper.
package ann_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        WAIT    = 3'd2,
        CAPTURE = 3'd3,
        OUTPUT  = 3'd4,
        DONE    = 3'd5
    } sched_state_t;

    // The neuron's accumulator carries eight guard bits over its input width.
    function automatic int RESULT_BITS(input int nb);
        return nb + 8;
    endfunction

endpackage

// File: rtl/layer_scheduler.sv
// Steps the shared neuron datapath through every output index of one layer
// and hands each captured result downstream over valid/ready.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start; activation select latched on accept
// FETCH   | weight row / bias read strobe for the current index
// WAIT    | memory + neuron input register latency (down-counter)
// CAPTURE | neuron result valid; registered into out_data/out_idx
// OUTPUT  | out_valid high; held until out_ready
// DONE    | one-cycle completion pulse
module layer_scheduler
    import ann_pkg::*;
#(
    parameter int NUM_NEURONS = 10,
    parameter int NEURON_BITS = 8,
    parameter int MEM_LATENCY = 1,
    parameter int IDX_BITS    = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic                                relu_en,
    output logic                                busy,
    output logic                                done,
    output logic                                mem_rd_en,
    output logic [IDX_BITS-1:0]                 mem_addr,
    output logic                                activation_func,
    input  logic [RESULT_BITS(NEURON_BITS)-1:0] neuron_result,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [IDX_BITS-1:0]                 out_idx,
    output logic [RESULT_BITS(NEURON_BITS)-1:0] out_data
);

    localparam int CNT_BITS = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [IDX_BITS-1:0] LAST_IDX  = IDX_BITS'(NUM_NEURONS - 1);
    localparam logic [CNT_BITS-1:0] WAIT_LOAD = CNT_BITS'(MEM_LATENCY - 1);

    sched_state_t        state;
    sched_state_t        state_next;
    logic [IDX_BITS-1:0] idx;
    logic [CNT_BITS-1:0] wait_cnt;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = FETCH;
            FETCH:   state_next = WAIT;
            WAIT:    if (wait_cnt == '0) state_next = CAPTURE;
            CAPTURE: state_next = OUTPUT;
            OUTPUT:  if (out_ready) state_next = (idx == LAST_IDX) ? DONE : FETCH;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // busy/out_valid are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            idx             <= '0;
            wait_cnt        <= '0;
            busy            <= 1'b0;
            out_valid       <= 1'b0;
            activation_func <= 1'b0;
            out_idx         <= '0;
            out_data        <= '0;
        end else begin
            state     <= state_next;
            busy      <= (state_next != IDLE);
            out_valid <= (state_next == OUTPUT);
            case (state)
                IDLE: begin
                    if (start) begin
                        activation_func <= relu_en;
                        idx             <= '0;
                    end
                end
                FETCH: wait_cnt <= WAIT_LOAD;
                WAIT: begin
                    if (wait_cnt != '0) wait_cnt <= wait_cnt - 1'b1;
                end
                CAPTURE: begin
                    out_data <= neuron_result;
                    out_idx  <= idx;
                end
                OUTPUT: begin
                    if (out_ready && (idx != LAST_IDX)) idx <= idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign mem_rd_en = (state == FETCH);
    assign mem_addr  = idx;
    assign done      = (state == DONE);

endmodule

// File: tb/tb_layer_scheduler.sv
// Directed bench for layer_scheduler: two instances (memory latency 1 and 3),
// a registered neuron model, and a negedge monitor logging handshakes.
module tb_layer_scheduler;

    typedef struct {
        int idx;
        int data;
        int rel;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_a = 1'b0, start_b = 1'b0;
    logic relu_en = 1'b0;
    logic ready = 1'b0;
    logic neg_mode = 1'b0;
    logic sel = 1'b0;

    logic        busy_a, done_a, rd_a, act_a, valid_a;
    logic [1:0]  addr_a, oidx_a, addr_qa;
    logic [15:0] data_a, nr_a;
    logic        busy_b, done_b, rd_b, act_b, valid_b;
    logic [1:0]  addr_b, oidx_b, addr_qb;
    logic [15:0] data_b, nr_b;

    logic        m_busy, m_done, m_rd, m_act, m_valid;
    logic [1:0]  m_addr, m_idx;
    logic [15:0] m_data;

    int cyc = 0;
    int t0 = 0;
    int checks = 0;
    int failures = 0;

    vec_t hs[$];
    int   rd_cnt, done_cnt, done_rel, first_valid_rel;
    bit   rd_consec, prev_rd, act_bad, exp_act;

    layer_scheduler #(.NUM_NEURONS(3), .NEURON_BITS(8), .MEM_LATENCY(1)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .relu_en(relu_en),
        .busy(busy_a), .done(done_a), .mem_rd_en(rd_a), .mem_addr(addr_a),
        .activation_func(act_a), .neuron_result(nr_a), .out_valid(valid_a),
        .out_ready(ready), .out_idx(oidx_a), .out_data(data_a)
    );

    layer_scheduler #(.NUM_NEURONS(3), .NEURON_BITS(8), .MEM_LATENCY(3)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .relu_en(relu_en),
        .busy(busy_b), .done(done_b), .mem_rd_en(rd_b), .mem_addr(addr_b),
        .activation_func(act_b), .neuron_result(nr_b), .out_valid(valid_b),
        .out_ready(ready), .out_idx(oidx_b), .out_data(data_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] model(input logic [1:0] a);
        if (neg_mode) return 16'hFED4;
        return 16'(int'(a) * 10 + 5);
    endfunction

    // Memory latches the row on the strobe; the neuron registers it one edge later.
    always @(posedge clk) begin
        if (rd_a) addr_qa <= addr_a;
        if (rd_b) addr_qb <= addr_b;
        nr_a <= model(addr_qa);
        nr_b <= model(addr_qb);
    end

    assign m_busy  = sel ? busy_b  : busy_a;
    assign m_done  = sel ? done_b  : done_a;
    assign m_rd    = sel ? rd_b    : rd_a;
    assign m_act   = sel ? act_b   : act_a;
    assign m_valid = sel ? valid_b : valid_a;
    assign m_addr  = sel ? addr_b  : addr_a;
    assign m_idx   = sel ? oidx_b  : oidx_a;
    assign m_data  = sel ? data_b  : data_a;

    always @(negedge clk) begin
        if (m_valid && ready) hs.push_back('{int'(m_idx), int'(m_data), cyc - t0});
        if (m_rd) begin
            rd_cnt++;
            if (prev_rd) rd_consec = 1'b1;
        end
        prev_rd = m_rd;
        if (m_done) begin
            done_cnt++;
            done_rel = cyc - t0;
        end
        if (m_valid && first_valid_rel < 0) first_valid_rel = cyc - t0;
        if (m_busy && (m_act != exp_act)) act_bad = 1'b1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        hs.delete();
        rd_cnt = 0;
        done_cnt = 0;
        done_rel = -1;
        first_valid_rel = -1;
        rd_consec = 1'b0;
        prev_rd = 1'b0;
        act_bad = 1'b0;
    endtask

    task automatic do_start();
        if (sel) start_b = 1'b1;
        else     start_a = 1'b1;
        tick();
        start_a = 1'b0;
        start_b = 1'b0;
        t0 = cyc - 1;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            tick();
            n++;
        end
        if (done_cnt == 0) chk("done_timeout", 0, 1);
        tick();
        tick();
    endtask

    task automatic wait_valid_idx(input int target, input int budget);
        int n = 0;
        while (!(m_valid && int'(m_idx) == target) && n < budget) begin
            tick();
            n++;
        end
        if (!(m_valid && int'(m_idx) == target)) chk("valid_timeout", 0, 1);
    endtask

    task automatic check_hs(input string name, input vec_t tbl[3], input int exp_done_rel);
        chk({name, "_count"}, hs.size(), 3);
        for (int i = 0; i < 3; i++) begin
            if (i < hs.size()) begin
                chk({name, "_idx"},  hs[i].idx,  tbl[i].idx);
                chk({name, "_data"}, hs[i].data, tbl[i].data);
                chk({name, "_rel"},  hs[i].rel,  tbl[i].rel);
            end
        end
        chk({name, "_done_cnt"}, done_cnt, 1);
        chk({name, "_done_rel"}, done_rel, exp_done_rel);
        chk({name, "_rd_cnt"}, rd_cnt, 3);
    endtask

    task automatic check_reset_outputs(input string name);
        chk({name, "_busy"},  int'(busy_a),  0);
        chk({name, "_done"},  int'(done_a),  0);
        chk({name, "_rd"},    int'(rd_a),    0);
        chk({name, "_addr"},  int'(addr_a),  0);
        chk({name, "_act"},   int'(act_a),   0);
        chk({name, "_valid"}, int'(valid_a), 0);
        chk({name, "_oidx"},  int'(oidx_a),  0);
        chk({name, "_odata"}, int'(data_a),  0);
    endtask

    initial begin
        vec_t tbl_basic[3];
        vec_t tbl_bp[3];
        vec_t tbl_lat3[3];
        vec_t tbl_neg[3];
        tbl_basic = '{'{0, 5, 4},  '{1, 15, 8},  '{2, 25, 12}};
        tbl_bp    = '{'{0, 5, 4},  '{1, 15, 13}, '{2, 25, 17}};
        tbl_lat3  = '{'{0, 5, 6},  '{1, 15, 12}, '{2, 25, 18}};
        tbl_neg   = '{'{0, 65236, 4}, '{1, 65236, 8}, '{2, 65236, 12}};

        clear_mon();
        exp_act = 1'b1;
        rst = 1'b1;
        repeat (3) tick();
        check_reset_outputs("reset");
        chk("reset_busy_b", int'(busy_b), 0);
        rst = 1'b0;
        tick();

        // basic pass, latency 1
        sel = 1'b0; relu_en = 1'b1; ready = 1'b1;
        clear_mon();
        do_start();
        chk("basic_fetch_rd", int'(rd_a), 1);
        chk("basic_fetch_addr", int'(addr_a), 0);
        chk("basic_act", int'(act_a), 1);
        wait_done(60);
        check_hs("basic", tbl_basic, 13);
        chk("basic_idle_busy", int'(busy_a), 0);

        // backpressure on index 1
        clear_mon();
        do_start();
        wait_valid_idx(1, 40);
        ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_valid", int'(valid_a), 1);
            chk("bp_data", int'(data_a), 15);
            chk("bp_idx", int'(oidx_a), 1);
            chk("bp_no_fetch", int'(rd_a), 0);
        end
        ready = 1'b1;
        wait_done(60);
        check_hs("bp", tbl_bp, 18);

        // latency 3 instance
        sel = 1'b1;
        clear_mon();
        do_start();
        wait_done(80);
        check_hs("lat3", tbl_lat3, 19);
        chk("lat3_first_valid", first_valid_rel, 6);
        chk("lat3_rd_single", int'(rd_consec), 0);

        // start and relu_en disturbances mid-pass
        sel = 1'b0;
        clear_mon();
        do_start();
        wait_valid_idx(1, 40);
        relu_en = 1'b0;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        relu_en = 1'b1;
        tick();
        relu_en = 1'b0;
        wait_done(60);
        chk("dist_count", hs.size(), 3);
        chk("dist_done_cnt", done_cnt, 1);
        chk("dist_act_stable", int'(act_bad), 0);
        repeat (3) tick();
        chk("dist_no_restart", int'(busy_a), 0);
        relu_en = 1'b1;

        // reset while presenting index 1
        clear_mon();
        do_start();
        wait_valid_idx(1, 40);
        rst = 1'b1;
        tick();
        check_reset_outputs("midrst");
        rst = 1'b0;
        tick();
        chk("midrst_done_cnt", done_cnt, 0);
        clear_mon();
        do_start();
        chk("midrst_restart_rd", int'(rd_a), 1);
        chk("midrst_restart_addr", int'(addr_a), 0);
        wait_done(60);
        check_hs("midrst", tbl_basic, 13);

        // negative result passes through unchanged
        neg_mode = 1'b1;
        clear_mon();
        do_start();
        wait_done(60);
        check_hs("neg", tbl_neg, 13);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
